adder_pipe: RTL and testbench

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pkg.sv | 35 +++
 rtl/adder_stage.sv | 67 ++++++
 rtl/adder_pipe.sv | 144 ++++++++++++++
 tb/tb_adder_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the adder_pipe reduction pipeline.
package adder_pkg;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Number of operands entering tree level lvl (level 0 sees all num operands).
  function automatic int unsigned level_num(input int unsigned num, input int unsigned lvl);
    int unsigned n;
    n = num;
    for (int unsigned s = 0; s < lvl; s++) n = (n + 1) / 2;
    return n;
  endfunction

  // Accumulator width: operand width, one bit per tree level, plus beat headroom.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned num,
                                            input int unsigned beats);
    return width + clog2(num) + clog2(beats);
  endfunction

  // Signed range limits of a width-bit result.
  function automatic longint sat_hi(input int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One registered level of the adder tree: pairwise signed add, odd leftover passes
// through sign-extended. Data, valid and last advance only when en is high.
module adder_stage #(
  parameter int unsigned IN_NUM   = 2,
  parameter int unsigned IN_WIDTH = 8
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              en,
  input  logic                                              in_valid,
  input  logic                                              in_last,
  input  logic [IN_NUM*IN_WIDTH-1:0]                        in_data,
  output logic                                              out_valid,
  output logic                                              out_last,
  output logic [((IN_NUM+1)/2)*(IN_WIDTH+1)-1:0]            out_data
);

  localparam int unsigned OutNum   = (IN_NUM + 1) / 2;
  localparam int unsigned OutWidth = IN_WIDTH + 1;

  logic [OutNum*OutWidth-1:0] sum_w;
  logic [OutNum*OutWidth-1:0] data_d, data_q;
  logic                       valid_d, valid_q;
  logic                       last_d, last_q;

  for (genvar j = 0; j < OutNum; j++) begin : g_pair
    logic signed [IN_WIDTH-1:0] a;
    assign a = in_data[2*j*IN_WIDTH +: IN_WIDTH];
    if (2 * j + 1 < IN_NUM) begin : g_add
      logic signed [IN_WIDTH-1:0] b;
      assign b = in_data[(2*j+1)*IN_WIDTH +: IN_WIDTH];
      assign sum_w[j*OutWidth +: OutWidth] = OutWidth'(a) + OutWidth'(b);
    end else begin : g_pass
      assign sum_w[j*OutWidth +: OutWidth] = OutWidth'(a);
    end
  end

  // Next state: advance on enable; bubbles keep old data so nothing toggles needlessly.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (en) begin
      valid_d = in_valid;
      last_d  = in_valid && in_last;
      if (in_valid) data_d = sum_w;
    end
  end

  // Level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined packet summer: NUM signed operands per beat reduced by a registered
// adder tree, then accumulated per packet. Optional ADDER_PIPE_SAT_EN clamps an
// out-of-range sum instead of wrapping it.
module adder_pipe import adder_pkg::*; #(
  parameter int unsigned NUM           = 4,
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned ACC_BEATS_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM*WIDTH-1:0] i,
  input  logic                 i_valid,
  input  logic                 i_last,
  output logic                 i_ready,
  output logic [WIDTH-1:0]     o,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic                 o_ovf
);

  localparam int unsigned L    = clog2(NUM);
  localparam int unsigned TW   = WIDTH + L;
  localparam int unsigned AW   = acc_width(WIDTH, NUM, ACC_BEATS_MAX);
  localparam int unsigned CntW = (clog2(ACC_BEATS_MAX) > 0) ? clog2(ACC_BEATS_MAX) : 1;

  localparam logic signed [AW-1:0] SatHi = AW'(sat_hi(WIDTH));
  localparam logic signed [AW-1:0] SatLo = AW'(sat_lo(WIDTH));

  logic                 en;
  logic                 ready_d, ready_q;
  logic                 tree_valid, tree_last;
  logic signed [TW-1:0] tree_data;

  logic signed [AW-1:0] acc_d, acc_q, acc_base, sum_full;
  logic [CntW-1:0]      cnt_d, cnt_q;
  logic [WIDTH-1:0]     o_d, o_q, res;
  logic                 o_valid_d, o_valid_q, o_ovf_d, o_ovf_q;
  logic                 cnt_end, pkt_end, rng_ovf, beat, load;

  // The whole pipeline moves in lockstep; only a held result at the output stops it.
  assign en      = !(o_valid_q && !o_ready);
  assign i_ready = ready_q && en;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int unsigned InNum = level_num(NUM, k);
    localparam int unsigned InW   = WIDTH + k;
    logic [level_num(NUM, k + 1)*(InW+1)-1:0] data;
    logic                                     valid;
    logic                                     last;
    if (k == 0) begin : g_head
      adder_stage #(.IN_NUM(InNum), .IN_WIDTH(InW)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_valid (i_valid && i_ready),
        .in_last  (i_last),
        .in_data  (i),
        .out_valid(valid),
        .out_last (last),
        .out_data (data)
      );
    end else begin : g_body
      adder_stage #(.IN_NUM(InNum), .IN_WIDTH(InW)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_valid (g_lvl[k-1].valid),
        .in_last  (g_lvl[k-1].last),
        .in_data  (g_lvl[k-1].data),
        .out_valid(valid),
        .out_last (last),
        .out_data (data)
      );
    end
  end

  assign tree_data  = g_lvl[L-1].data;
  assign tree_valid = g_lvl[L-1].valid;
  assign tree_last  = g_lvl[L-1].last;

  // Accumulate: a zero beat count marks the first beat, which restarts the sum.
  always_comb begin
    acc_base = (cnt_q == '0) ? '0 : acc_q;
    sum_full = acc_base + AW'(tree_data);
    cnt_end  = (cnt_q == CntW'(ACC_BEATS_MAX - 1));
    pkt_end  = tree_last || cnt_end;
    rng_ovf  = (sum_full > SatHi) || (sum_full < SatLo);
    beat     = en && tree_valid;
    load     = beat && pkt_end;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (beat) begin
      acc_d = pkt_end ? '0 : sum_full;
      cnt_d = pkt_end ? '0 : cnt_q + 1'b1;
    end
  end

  // Result formatting and output register next state.
  always_comb begin
`ifdef ADDER_PIPE_SAT_EN
    // Clamp only a genuinely out-of-range sum; a forced packet end with an in-range
    // sum still reports o_ovf but keeps its exact value.
    if (rng_ovf) res = sum_full[AW-1] ? SatLo[WIDTH-1:0] : SatHi[WIDTH-1:0];
    else         res = sum_full[WIDTH-1:0];
`else
    res = sum_full[WIDTH-1:0];
`endif
    o_d       = o_q;
    o_ovf_d   = o_ovf_q;
    o_valid_d = o_valid_q && !o_ready;
    if (load) begin
      o_d       = res;
      o_ovf_d   = rng_ovf || (cnt_end && !tree_last);
      o_valid_d = 1'b1;
    end
  end

  // Ready comes up on the first clock edge after reset releases.
  always_comb ready_d = 1'b1;

  // Accumulator, beat counter, output and ready registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      o_ovf_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      o_ovf_q   <= o_ovf_d;
      ready_q   <= ready_d;
    end
  end

  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign o_ovf   = o_ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe with NUM=4, WIDTH=8, ACC_BEATS_MAX=4.
module tb_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i;
  logic        i_valid, i_last, i_ready;
  logic [7:0]  o;
  logic        o_valid, o_ready, o_ovf;

  typedef struct packed {
    logic [7:0] o;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  adder_pipe #(.NUM(4), .WIDTH(8), .ACC_BEATS_MAX(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i      (i),
    .i_valid(i_valid),
    .i_last (i_last),
    .i_ready(i_ready),
    .o      (o),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_ovf  (o_ovf)
  );

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out, expected event did not occur", nm);
  endfunction

  // Present one beat; returns at posedge+1 after it is accepted, pushing the packet
  // result when this beat ends the packet.
  task automatic send_beat(input logic [7:0] v, input logic last, input logic push,
                           input logic [7:0] eo, input logic eovf);
    logic acc;
    int   n;
    acc     = 1'b0;
    n       = 0;
    i       = {4{v}};
    i_valid = 1'b1;
    i_last  = last;
    while (!acc) begin
      @(negedge clk);
      acc = i_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 50) begin
        timeout("beat_accept");
        return;
      end
    end
    if (push) sb_q.push_back('{o: eo, ovf: eovf});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) timeout("drain");
    #1;
  endtask

  // Monitor: every transferred result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && o_valid && o_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got o=%0h ovf=%0b, expected no output", o, o_ovf);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_o", 32'(o), 32'(e.o));
        check("out_ovf", 32'(o_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    rst_n   = 1'b1;
    i       = '0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    o_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_o", 32'(o), 32'h0);
    check("rst_o_valid", 32'(o_valid), 32'h0);
    check("rst_o_ovf", 32'(o_ovf), 32'h0);
    check("rst_i_ready", 32'(i_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1 check("rst_hold_i_ready", 32'(i_ready), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_rst_i_ready", 32'(i_ready), 32'h1);

    // Single beat {1,2,3,4}: 10, visible three cycles after acceptance.
    i = {8'd4, 8'd3, 8'd2, 8'd1};
    i_valid = 1'b1;
    i_last  = 1'b1;
    @(negedge clk);
    check("lat_accept", 32'(i_ready), 32'h1);
    @(posedge clk);
    #1;
    sb_q.push_back('{o: 8'd10, ovf: 1'b0});
    i_valid = 1'b0;
    check("lat_c1", 32'(o_valid), 32'h0);
    @(posedge clk);
    #1 check("lat_c2", 32'(o_valid), 32'h0);
    @(posedge clk);
    #1 check("lat_c3", 32'(o_valid), 32'h1);

    // Three beats of 10s, then single-beat packets back to back.
    send_beat(8'd10, 1'b0, 1'b0, 8'd0, 1'b0);
    send_beat(8'd10, 1'b0, 1'b0, 8'd0, 1'b0);
    send_beat(8'd10, 1'b1, 1'b1, 8'd120, 1'b0);
    send_beat(8'hFF, 1'b1, 1'b1, 8'hFC, 1'b0);
`ifdef ADDER_PIPE_SAT_EN
    send_beat(8'd127, 1'b1, 1'b1, 8'h7F, 1'b1);
    send_beat(8'h80, 1'b1, 1'b1, 8'h80, 1'b1);
`else
    send_beat(8'd127, 1'b1, 1'b1, 8'hFC, 1'b1);
    send_beat(8'h80, 1'b1, 1'b1, 8'h00, 1'b1);
`endif
    i_valid = 1'b0;
    drain();

    // Backpressure: continuous two-beat packets while o_ready is held low.
    o_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          logic odd;
          odd = (k % 2) == 1;
          send_beat(8'(k + 1), odd, odd, 8'(4 * (2 * k + 1)), 1'b0);
        end
        i_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!o_valid && w < 30) begin
          @(negedge clk);
          w++;
        end
        if (!o_valid) timeout("stall_wait");
        for (int s = 0; s < 5; s++) begin
          check("stall_o", 32'(o), 32'd12);
          check("stall_o_valid", 32'(o_valid), 32'h1);
          check("stall_i_ready", 32'(i_ready), 32'h0);
          @(negedge clk);
        end
        @(posedge clk);
        #1 o_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-packet discards the partial sum.
    send_beat(8'd1, 1'b0, 1'b0, 8'd0, 1'b0);
    send_beat(8'd1, 1'b0, 1'b0, 8'd0, 1'b0);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_o", 32'(o), 32'h0);
    check("mid_rst_o_valid", 32'(o_valid), 32'h0);
    check("mid_rst_o_ovf", 32'(o_ovf), 32'h0);
    check("mid_rst_i_ready", 32'(i_ready), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("mid_rst_release_i_ready", 32'(i_ready), 32'h1);
    send_beat(8'd2, 1'b1, 1'b1, 8'd8, 1'b0);
    i_valid = 1'b0;
    drain();

    // No i_last: the fourth beat forces the end; the fifth starts a new packet.
    send_beat(8'd5, 1'b0, 1'b0, 8'd0, 1'b0);
    send_beat(8'd5, 1'b0, 1'b0, 8'd0, 1'b0);
    send_beat(8'd5, 1'b0, 1'b0, 8'd0, 1'b0);
    send_beat(8'd5, 1'b0, 1'b1, 8'd80, 1'b1);
    send_beat(8'd3, 1'b1, 1'b1, 8'd12, 1'b0);
    i_valid = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
